uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flops in the rx input synchronizer.
REQ-003 SHALL have port wb_clk_i  in  1  sole clock.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_i  in  1  serial input, idle high, async to wb_clk_i.
REQ-006 SHALL have port rx_en_i  in  1  receiver enable.
REQ-007 SHALL have port clk_div_i  in  16  clocks per bit, valid 4..65535.
REQ-008 SHALL have port rd_en_i  in  1  pop head entry.
REQ-009 SHALL have port err_clr_i  in  1  clear sticky error flags.
REQ-010 SHALL have port rd_data_o  out  8  FIFO head, first-word-fall-through.
REQ-011 SHALL have port fifo_count_o  out  clog2(FIFO_DEPTH)+1  occupancy.
REQ-012 SHALL have ports fifo_empty_o and fifo_full_o  out  1 each  occupancy flags.
REQ-013 SHALL have ports frame_err_o, overrun_o and parity_err_o  out  1 each  sticky errors.
REQ-014 SHALL have port irq_o  out  1  high while FIFO is not empty.

Function
REQ-015 SHALL synchronize rx_i through SYNC_STAGES flops, all reset to 1; the synchronized value drives all sampling.
REQ-016 SHALL implement FSM IDLE, START, DATA, STOP (plus PARITY when configured), with a 16-bit bit counter and a 3-bit bit index.
REQ-017 IDLE->START on a synchronized falling edge while rx_en_i=1; bit counter loads clk_div_i/2 - 1.
REQ-018 START: at counter 0, sampled low -> DATA with counter clk_div_i-1; sampled high -> IDLE, glitch ignored.
REQ-019 DATA SHALL sample 8 bits at clk_div_i intervals, LSB first, into a shift register; after bit 7 -> STOP.
REQ-020 STOP: sample 1 -> push byte; sample 0 -> set frame_err_o, discard byte; both -> IDLE in same cycle.
REQ-021 A pushed byte SHALL appear on rd_data_o and fifo_count_o the cycle after the stop sample.
REQ-022 Push while full and no pop in that cycle SHALL discard the new byte and set overrun_o; contents unchanged.
REQ-023 Push and pop in same cycle SHALL both take effect; count unchanged, no overrun even when full.
REQ-024 rd_en_i while empty SHALL be ignored; count stays 0, pointers unchanged.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full = count==FIFO_DEPTH, empty = count==0.
REQ-026 rx_en_i low SHALL force the FSM to IDLE next cycle, discarding any partial frame; FIFO unaffected.
REQ-027 err_clr_i SHALL clear all sticky flags next cycle; an error event in the same cycle wins (flag stays set).
REQ-028 clk_div_i SHALL be sampled only at IDLE->START; changes mid-frame take effect on the next frame.

Reset
REQ-029 wb_rst_i SHALL, at the next clock edge, force FSM IDLE, empty FIFO, count 0, rd_data_o 0, all error flags 0, irq_o 0, synchronizer to 1.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next complete frame SHALL be received correctly.

Configuration
REQ-031 With UART_RX_PARITY_EN defined, SHALL expect an even parity bit between DATA and STOP; a mismatch sets parity_err_o and discards the byte.
REQ-032 Without UART_RX_PARITY_EN, frame SHALL be 8N1; parity_err_o SHALL be tied 0 and no PARITY state exists.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state typedef, MIN_CLK_DIV=4 and default FIFO_DEPTH.
REQ-034 FIFO storage, pointers and count SHALL live in sub-module sync_fifo; uart_rx_fifo holds synchronizer, FSM and error flags.

Verification
REQ-035 clk_div_i=16, send 0x3D twice -> count 2, irq_o=1; two pops read 0x3D, 0x3D; empty=1, irq_o=0.
REQ-036 rx_i low for 4 clocks then high, clk_div_i=16 -> FSM returns to IDLE, count 0, no error flags.
REQ-037 Frame 0xA5 with stop bit 0 -> frame_err_o=1, count 0; pulse err_clr_i -> frame_err_o=0.
REQ-038 Send 9 bytes 0x01..0x09 with no reads -> full=1, overrun_o=1; reads return 0x01..0x08.
REQ-039 FIFO full, rd_en_i asserted in the cycle of a push of 0x55 -> count 8, overrun_o=0, 0x55 is last entry.
REQ-040 wb_rst_i during DATA of a frame, then send 0xC3 -> all outputs at reset values, then one entry 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN adds an even-parity bit between data and stop.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_t;
`endif

  localparam int MIN_CLK_DIV    = 4;
  localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count and overrun detect.
// Head reads as zero while empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A same-cycle pop frees the slot the push is about to use.
  assign do_push = push & (~full | do_pop);
  assign overrun = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        do_push & ~do_pop: count <= count + 1'b1;
        do_pop & ~do_push: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a FWFT FIFO.
// Holds input synchronizer, frame FSM and sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        rx_i,
  input  logic                        rx_en_i,
  input  logic [15:0]                 clk_div_i,
  input  logic                        rd_en_i,
  input  logic                        err_clr_i,
  output logic [7:0]                  rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        fifo_empty_o,
  output logic                        fifo_full_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  output logic                        parity_err_o,
  output logic                        irq_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_d;
  logic                   fall;

  rx_state_t   state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [15:0] div_q, div_n;
  logic [2:0]  idx_q, idx_n;
  logic [7:0]  shr_q, shr_n;
  logic        cnt_zero;
  logic        push;
  logic        frame_evt;
  logic        par_evt;
  logic        ovr_evt;
  logic        par_bad;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall     = rx_d & ~rx_s;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_d   <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic bad_q, bad_n;
  assign par_bad = bad_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) bad_q <= 1'b0;
    else          bad_q <= bad_n;
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      shr_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      div_q   <= div_n;
      idx_q   <= idx_n;
      shr_q   <= shr_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    div_n     = div_q;
    idx_n     = idx_q;
    shr_n     = shr_q;
    push      = 1'b0;
    frame_evt = 1'b0;
    par_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_n     = bad_q;
`endif
    if (!rx_en_i) begin
      state_n = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_n = S_START;
            div_n   = clk_div_i;
            cnt_n   = (clk_div_i >> 1) - 16'd1;
          end
        end
        S_START: begin
          if (!cnt_zero) begin
            cnt_n = cnt_q - 16'd1;
          end else if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            cnt_n   = div_q - 16'd1;
            idx_n   = '0;
          end
        end
        S_DATA: begin
          if (!cnt_zero) begin
            cnt_n = cnt_q - 16'd1;
          end else begin
            shr_n = {rx_s, shr_q[7:1]};
            cnt_n = div_q - 16'd1;
            idx_n = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (!cnt_zero) begin
            cnt_n = cnt_q - 16'd1;
          end else begin
            bad_n   = ^{shr_q, rx_s};
            par_evt = bad_n;
            cnt_n   = div_q - 16'd1;
            state_n = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (!cnt_zero) begin
            cnt_n = cnt_q - 16'd1;
          end else begin
            state_n   = S_IDLE;
            frame_evt = ~rx_s;
            push      = rx_s & ~par_bad;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (push),
    .pop     (rd_en_i),
    .wdata   (shr_q),
    .rdata   (rd_data_o),
    .count   (fifo_count_o),
    .empty   (fifo_empty_o),
    .full    (fifo_full_o),
    .overrun (ovr_evt)
  );

  assign irq_o = ~fifo_empty_o;

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_evt | (frame_err_o & ~err_clr_i);
      overrun_o   <= ovr_evt | (overrun_o & ~err_clr_i);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) parity_err_o <= 1'b0;
    else          parity_err_o <= par_evt | (parity_err_o & ~err_clr_i);
  end
`else
  assign parity_err_o = 1'b0;
  logic unused_par;
  assign unused_par = par_evt;
`endif

endmodule
